fix_byte_serializer: RTL and testbench
======================================

// Module: fix_byte_serializer
// PURPOSE
//  Downstream of the FIX message-creation FSM. Takes one tag/value field at a time,
//  serializes it LSB-byte-first as ASCII "tag=value<SOH>" onto a byte stream, and keeps
//  a running mod-256 checksum. When the creator flags the checksum tag, it appends
//  "10=ddd<SOH>". It returns done/end handshakes that pace the creator FSM.
// PARAMETERS
//  VALUE_WIDTH  256  value bus width in bits; VALUE_WIDTH/8 = max value bytes (32)
//  SIZE         64   value byte-mask width; only bits [VALUE_WIDTH/8-1:0] are used
// PORTS
//  clk             in   1            clock, rising edge
//  rst             in   1            synchronous, active-low reset
//  tag_i           in   32           tag ASCII bytes, byte0 = [7:0] sent first
//  tag_valid_i     in   1            one-cycle pulse: tag_i/t_size_i/checksum_i valid
//  t_size_i        in   5            tag byte mask; bits [3:0] used, bit4 ignored
//  val_i           in   VALUE_WIDTH  value ASCII bytes, byte0 sent first
//  val_valid_i     in   1            one-cycle pulse: val_i/v_size_i valid
//  v_size_i        in   SIZE         value byte mask (thermometer, e.g. 7 = 3 bytes)
//  checksum_i      in   1            sampled with tag_valid_i: 1 = emit checksum trailer
//  byte_o          out  8            serialized byte
//  byte_valid_o    out  1            byte_o valid; held stable until byte_ready_i
//  byte_ready_i    in   1            downstream accept; transfer = valid & ready
//  done_o          out  1            one-cycle pulse: field (tag or value) fully sent
//  end_o           out  1            one-cycle pulse: checksum trailer fully sent
//  busy_o          out  1            high when not IDLE and not WAIT_VAL
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, checksum=0, byte_o=0, byte_valid_o=0,
//    done_o=0, end_o=0, busy_o=0. This applies mid-field too: any partial byte is dropped.
//  - Byte count = (index of highest set mask bit)+1; bytes 0..count-1 are sent in order.
//    A zero mask sends no field bytes, only the delimiter.
//  - States: IDLE -> TAG -> EQ -> WAIT_VAL -> VAL -> SOH -> IDLE(done).
//    Checksum path: IDLE -> CK_TAG -> CK_EQ -> CK_D2 -> CK_D1 -> CK_D0 -> CK_SOH -> IDLE(end).
//  - IDLE: on tag_valid_i, latch tag, mask and checksum_i. Next state is CK_TAG if
//    checksum_i=1, else TAG. The first byte_valid_o is asserted the cycle after the pulse.
//  - TAG/CK_TAG: advance the byte index on each transfer. After the last tag byte, go to
//    EQ/CK_EQ and emit 0x3D ('=').
//  - EQ transfer: pulse done_o for 1 cycle on the next cycle, then go to WAIT_VAL.
//  - WAIT_VAL: on val_valid_i, latch value and mask, go to VAL. After the last value byte,
//    go to SOH and emit 0x01. When SOH transfers, pulse done_o next cycle and return to IDLE.
//  - Checksum accumulation: every byte transferred outside the CK_* states is added
//    mod 256 (8-bit wrap).
//  - Checksum trailer: CK_D2/D1/D0 emit 0x30 + hundreds/tens/units of the latched sum,
//    always 3 digits with leading zeros. The sum is frozen on entry to CK_TAG.
//  - CK_SOH transfer: pulse end_o next cycle (no done_o), clear checksum to 0, go to IDLE.
//  - Ignored pulses: tag_valid_i outside IDLE; val_valid_i outside WAIT_VAL;
//    checksum_i when tag_valid_i=0. None of these change state.
//  - Simultaneous tag_valid_i and val_valid_i in IDLE: the tag is taken, the value dropped.
//  - Backpressure: while byte_ready_i=0, byte_o, the index, the state and the checksum
//    all hold. No combinational path from byte_ready_i to byte_o.
//  - Minimum latency: 1-byte tag = 3 cycles from tag_valid_i to done_o with ready held at 1.
// TESTING
//  1. tag_i=16'h3433, t_size_i=5'b00011 -> bytes 33,34,3D, then done_o 1 cycle; busy_o=0
//     while in WAIT_VAL.
//  2. After test 1, val_i=8'h61, v_size_i=1 -> bytes 61,01, then done_o; state=IDLE.
//  3. From reset: tag 8'h38/1, value 8'h41/1, then checksum tag 16'h3031/3 with
//     checksum_i=1 -> 38 3D 41 01 31 30 3D 31 38 33 01 (sum 183), end_o pulse,
//     checksum reset to 0.
//  4. Wrap: tag 8'h38/1, value 32'hFFFFFFFF/4'b1111, then checksum tag -> digits
//     31 31 34 ("114" = 1138 mod 256).
//  5. Backpressure: byte_ready_i=0 for 3 cycles on the 2nd tag byte -> byte_o=34 and
//     byte_valid_o held; no duplicate bytes; sum unchanged.
//  6. Reset mid-value: rst=0 during the 2nd value byte -> next cycle byte_valid_o=0 and
//     IDLE. A new tag is then accepted, and its checksum counts from 0.
//  7. Zero mask: v_size_i=0 -> only 01 is sent, then done_o.
//     tag_valid_i pulsed during VAL -> ignored, output stream unchanged.

Source files
------------

// File: rtl/fix_byte_serializer_if.sv
// fix_byte_serializer_if: field-in / byte-out bus between the FIX creator FSM and the serializer.
//   tag_i/t_size_i/checksum_i + tag_valid_i : tag field and checksum-trailer request
//   val_i/v_size_i + val_valid_i            : value field
//   byte_o/byte_valid_o/byte_ready_i        : serialized byte stream (valid/ready)
//   done_o/end_o/busy_o                     : pacing feedback to the creator
interface fix_byte_serializer_if #(
  parameter int VALUE_WIDTH = 256,
  parameter int SIZE = 64
);
  logic [31:0] tag_i;
  logic tag_valid_i;
  logic [4:0] t_size_i;
  logic [VALUE_WIDTH-1:0] val_i;
  logic val_valid_i;
  logic [SIZE-1:0] v_size_i;
  logic checksum_i;
  logic [7:0] byte_o;
  logic byte_valid_o;
  logic byte_ready_i;
  logic done_o;
  logic end_o;
  logic busy_o;
  modport master (
    output tag_i, tag_valid_i, t_size_i, val_i, val_valid_i, v_size_i, checksum_i, byte_ready_i,
    input byte_o, byte_valid_o, done_o, end_o, busy_o
  );
  modport slave (
    input tag_i, tag_valid_i, t_size_i, val_i, val_valid_i, v_size_i, checksum_i, byte_ready_i,
    output byte_o, byte_valid_o, done_o, end_o, busy_o
  );
endinterface

// File: rtl/fix_byte_serializer.sv
// fix_byte_serializer: serializes FIX "tag=value<SOH>" fields LSB-byte-first, keeps a mod-256
// checksum and appends "10=ddd<SOH>" when the creator flags the checksum tag.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : slave side of fix_byte_serializer_if (field inputs, byte stream, done/end/busy)
module fix_byte_serializer #(
  parameter int VALUE_WIDTH = 256,
  parameter int SIZE = 64
) (
  input logic clk,
  input logic rst,
  fix_byte_serializer_if.slave bus
);
  localparam int VB = VALUE_WIDTH / 8;
  typedef enum logic [3:0] {
    IDLE, TAG, EQ, WAIT_VAL, VAL, SOH, CK_TAG, CK_EQ, CK_D2, CK_D1, CK_D0, CK_SOH
  } state_t;
  state_t state;
  logic [31:0] tagReg;
  logic [VALUE_WIDTH-1:0] valReg;
  logic [5:0] cnt, idx, nxt, tagCnt, valCnt;
  logic [7:0] sum, d2, d1, d0;
  logic xfer, ckState, unusedBits;
  // Number of bytes to send is set by the highest set mask bit, not by the popcount.
  function automatic logic [5:0] msbCount(input logic [VB-1:0] m);
    msbCount = '0;
    for (int i = 0; i < VB; i++) if (m[i]) msbCount = 6'(i + 1);
  endfunction
  assign tagCnt = msbCount(VB'(bus.t_size_i[3:0]));
  assign valCnt = msbCount(bus.v_size_i[VB-1:0]);
  assign unusedBits = ^{bus.t_size_i[4], bus.v_size_i[SIZE-1:VB]};
  assign xfer = bus.byte_valid_o && bus.byte_ready_i;
  assign nxt = idx + 6'd1;
  assign ckState = state inside {CK_TAG, CK_EQ, CK_D2, CK_D1, CK_D0, CK_SOH};
  assign bus.busy_o = !(state inside {IDLE, WAIT_VAL});
  assign d2 = 8'h30 + sum / 8'd100;
  assign d1 = 8'h30 + (sum / 8'd10) % 8'd10;
  assign d0 = 8'h30 + sum % 8'd10;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sum <= '0;
      tagReg <= '0;
      valReg <= '0;
      cnt <= '0;
      idx <= '0;
      bus.byte_o <= '0;
      bus.byte_valid_o <= 1'b0;
      bus.done_o <= 1'b0;
      bus.end_o <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      bus.end_o <= 1'b0;
      // The trailer digits come from sum, so it only accumulates outside the checksum path.
      if (xfer) sum <= ckState ? (state == CK_SOH ? 8'd0 : sum) : sum + bus.byte_o;
      case (state)
        IDLE: if (bus.tag_valid_i) begin
          tagReg <= bus.tag_i;
          cnt <= tagCnt;
          idx <= '0;
          bus.byte_valid_o <= 1'b1;
          if (tagCnt == 6'd0) begin
            state <= bus.checksum_i ? CK_EQ : EQ;
            bus.byte_o <= 8'h3D;
          end else begin
            state <= bus.checksum_i ? CK_TAG : TAG;
            bus.byte_o <= bus.tag_i[7:0];
          end
        end
        TAG, CK_TAG: if (xfer) begin
          if (nxt < cnt) begin
            idx <= nxt;
            bus.byte_o <= tagReg[{nxt[1:0], 3'b000} +: 8];
          end else begin
            state <= state == TAG ? EQ : CK_EQ;
            bus.byte_o <= 8'h3D;
          end
        end
        EQ: if (xfer) begin
          state <= WAIT_VAL;
          bus.byte_valid_o <= 1'b0;
          bus.done_o <= 1'b1;
        end
        WAIT_VAL: if (bus.val_valid_i) begin
          valReg <= bus.val_i;
          cnt <= valCnt;
          idx <= '0;
          bus.byte_valid_o <= 1'b1;
          if (valCnt == 6'd0) begin
            state <= SOH;
            bus.byte_o <= 8'h01;
          end else begin
            state <= VAL;
            bus.byte_o <= bus.val_i[7:0];
          end
        end
        VAL: if (xfer) begin
          if (nxt < cnt) begin
            idx <= nxt;
            bus.byte_o <= valReg[{nxt, 3'b000} +: 8];
          end else begin
            state <= SOH;
            bus.byte_o <= 8'h01;
          end
        end
        SOH: if (xfer) begin
          state <= IDLE;
          bus.byte_valid_o <= 1'b0;
          bus.done_o <= 1'b1;
        end
        CK_EQ: if (xfer) begin
          state <= CK_D2;
          bus.byte_o <= d2;
        end
        CK_D2: if (xfer) begin
          state <= CK_D1;
          bus.byte_o <= d1;
        end
        CK_D1: if (xfer) begin
          state <= CK_D0;
          bus.byte_o <= d0;
        end
        CK_D0: if (xfer) begin
          state <= CK_SOH;
          bus.byte_o <= 8'h01;
        end
        CK_SOH: if (xfer) begin
          state <= IDLE;
          bus.byte_valid_o <= 1'b0;
          bus.end_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fix_byte_serializer.sv
// tb_fix_byte_serializer: self-checking bench for fix_byte_serializer against a byte-string model.
module tb_fix_byte_serializer;
  localparam int VW = 256;
  localparam int SZ = 64;
  typedef struct {
    logic [31:0] tag;
    logic [4:0] ts;
    logic [63:0] val;
    logic [7:0] vs;
    int expLen;
  } vec_t;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  fix_byte_serializer_if #(.VALUE_WIDTH(VW), .SIZE(SZ)) bus();
  fix_byte_serializer #(.VALUE_WIDTH(VW), .SIZE(SZ)) dut (.clk(clk), .rst(rst), .bus(bus));
  int passed = 0, total = 0, doneCnt = 0, endCnt = 0, refSum = 0, lastLen = 0;
  bit randReady = 0;
  logic [7:0] got[$], expq[$];
  string lastGot;
  always @(negedge clk) begin
    if (rst && bus.byte_valid_o && bus.byte_ready_i) got.push_back(bus.byte_o);
    if (bus.done_o) doneCnt++;
    if (bus.end_o) endCnt++;
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic checkStr(input string name, input string act, input string exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got [%s], expected [%s]", name, act, exp);
  endtask
  function automatic int msbCnt(input logic [63:0] m, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (m[i]) c = i + 1;
    return c;
  endfunction
  function automatic void pushSum(input logic [7:0] b);
    expq.push_back(b);
    refSum = (refSum + int'(b)) % 256;
  endfunction
  function automatic void expTag(input logic [31:0] t, input logic [4:0] ts, input bit ck);
    string s;
    for (int i = 0; i < msbCnt(64'(ts[3:0]), 4); i++)
      if (ck) expq.push_back(t[8*i +: 8]);
      else pushSum(t[8*i +: 8]);
    if (!ck) pushSum(8'h3D);
    else begin
      expq.push_back(8'h3D);
      s = $sformatf("%03d", refSum);
      for (int i = 0; i < 3; i++) expq.push_back(8'(s[i]));
      expq.push_back(8'h01);
      refSum = 0;
    end
  endfunction
  function automatic void expVal(input logic [VW-1:0] v, input logic [SZ-1:0] vs);
    for (int i = 0; i < msbCnt(vs, 32); i++) pushSum(v[8*i +: 8]);
    pushSum(8'h01);
  endfunction
  function automatic string hexStr(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) begin
      if (i > 0) s = {s, " "};
      s = {s, $sformatf("%02h", q[i])};
    end
    return s;
  endfunction
  task automatic compareBytes(input string name);
    bit ok = (got.size() == expq.size());
    if (ok) foreach (got[i]) if (got[i] !== expq[i]) ok = 0;
    total++;
    lastGot = hexStr(got);
    lastLen = got.size();
    if (ok) passed++;
    else $display("FAIL %s: got [%s], expected [%s]", name, lastGot, hexStr(expq));
    got.delete();
    expq.delete();
  endtask
  task automatic sendTag(input logic [31:0] t, input logic [4:0] ts, input bit ck);
    bus.tag_i = t;
    bus.t_size_i = ts;
    bus.checksum_i = ck;
    bus.tag_valid_i = 1;
    @(posedge clk);
    #1;
    bus.tag_valid_i = 0;
    bus.checksum_i = 1'($urandom_range(0, 1));
  endtask
  task automatic sendVal(input logic [VW-1:0] v, input logic [SZ-1:0] vs);
    bus.val_i = v;
    bus.v_size_i = vs;
    bus.val_valid_i = 1;
    @(posedge clk);
    #1;
    bus.val_valid_i = 0;
  endtask
  task automatic waitFor(input bit isEnd, input string name, output int n);
    for (n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (isEnd ? bus.end_o : bus.done_o) return;
      @(posedge clk);
      #1;
      if (randReady) bus.byte_ready_i = 1'($urandom_range(0, 1));
    end
    total++;
    $display("FAIL %s: got no pulse within 400 cycles, expected a pulse", name);
  endtask
  task automatic doField(input logic [31:0] t, input logic [4:0] ts, input logic [VW-1:0] v,
                         input logic [SZ-1:0] vs, input string name);
    int n;
    sendTag(t, ts, 0);
    expTag(t, ts, 0);
    waitFor(0, {name, "_tag_done"}, n);
    check({name, "_wait_val_idle"}, {bus.busy_o, bus.byte_valid_o}, 0);
    sendVal(v, vs);
    expVal(v, vs);
    waitFor(0, {name, "_val_done"}, n);
    compareBytes(name);
  endtask
  task automatic doCk(input logic [31:0] t, input logic [4:0] ts, input string name);
    int n, d0, e0;
    @(negedge clk);
    d0 = doneCnt;
    e0 = endCnt;
    sendTag(t, ts, 1);
    expTag(t, ts, 1);
    waitFor(1, {name, "_end"}, n);
    @(negedge clk);
    check({name, "_end_pulses"}, 64'(endCnt - e0), 1);
    check({name, "_no_done"}, 64'(doneCnt - d0), 0);
    compareBytes(name);
  endtask
  task automatic doReset(input string name);
    rst = 0;
    bus.tag_valid_i = 0;
    bus.val_valid_i = 0;
    bus.byte_ready_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(name, {bus.byte_o, bus.byte_valid_o, bus.done_o, bus.end_o, bus.busy_o}, 0);
    rst = 1;
    refSum = 0;
    got.delete();
    expq.delete();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t vecs[5];
    int n, c;
    logic [VW-1:0] v;
    logic [SZ-1:0] vs;
    logic [31:0] lowMask;
    vecs[0] = '{32'h3433, 5'b00011, 64'h61, 8'h01, 5};
    vecs[1] = '{32'h38, 5'b00001, 64'h41, 8'h01, 4};
    vecs[2] = '{32'h35343332, 5'b11111, 64'h4241, 8'h03, 8};
    vecs[3] = '{32'h39, 5'b00101, 64'h41, 8'h00, 5};
    vecs[4] = '{32'h3132, 5'b00000, 64'h434241, 8'h04, 5};
    bus.tag_i = 0;
    bus.t_size_i = 0;
    bus.val_i = 0;
    bus.v_size_i = 0;
    bus.checksum_i = 0;
    bus.tag_valid_i = 0;
    bus.val_valid_i = 0;
    bus.byte_ready_i = 1;
    doReset("reset_state");
    sendTag(32'h3433, 5'b00011, 0);
    expTag(32'h3433, 5'b00011, 0);
    waitFor(0, "t1_tag_done", n);
    check("t1_tag_latency", 64'(n), 4);
    check("t1_wait_val_busy", {bus.busy_o, bus.byte_valid_o}, 0);
    @(negedge clk);
    check("t1_done_one_cycle", bus.done_o, 0);
    sendVal(8'h61, 1);
    expVal(8'h61, 1);
    waitFor(0, "t1_val_done", n);
    compareBytes("t1_bytes");
    checkStr("t1_stream", lastGot, "33 34 3d 61 01");
    @(negedge clk);
    check("t1_back_idle", {bus.busy_o, bus.byte_valid_o}, 0);
    doReset("t3_reset_state");
    sendTag(32'h38, 5'b00001, 0);
    expTag(32'h38, 5'b00001, 0);
    waitFor(0, "t3_tag_done", n);
    check("t3_min_latency", 64'(n), 3);
    sendVal(8'h41, 1);
    expVal(8'h41, 1);
    waitFor(0, "t3_val_done", n);
    compareBytes("t3_field");
    checkStr("t3_stream", lastGot, "38 3d 41 01");
    doCk(32'h3031, 5'b00011, "t3_ck");
    checkStr("t3_trailer", lastGot, "31 30 3d 31 38 33 01");
    doField(32'h38, 5'b00001, 32'hFFFFFFFF, 4'b1111, "t4_field");
    doCk(32'h3031, 5'b00011, "t4_ck");
    checkStr("t4_trailer", lastGot, "31 30 3d 31 31 34 01");
    sendTag(32'h3433, 5'b00011, 0);
    expTag(32'h3433, 5'b00011, 0);
    @(posedge clk);
    #1;
    bus.byte_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5_hold%0d", i), {bus.byte_valid_o, bus.byte_o}, {1'b1, 8'h34});
      @(posedge clk);
      #1;
    end
    bus.byte_ready_i = 1;
    waitFor(0, "t5_tag_done", n);
    sendVal(8'h61, 1);
    expVal(8'h61, 1);
    waitFor(0, "t5_val_done", n);
    compareBytes("t5_bytes");
    doCk(32'h3031, 5'b00011, "t5_ck");
    sendTag(32'h38, 5'b00001, 0);
    waitFor(0, "t6_tag_done", n);
    sendVal(24'h434241, 3'b111);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    check("t6_reset_mid_value", {bus.byte_valid_o, bus.busy_o, bus.done_o}, 0);
    rst = 1;
    got.delete();
    expq.delete();
    refSum = 0;
    doField(32'h3132, 5'b00011, 8'h7a, 1, "t6_field");
    doCk(32'h3031, 5'b00011, "t6_ck");
    doField(32'h39, 5'b00001, 8'h41, 0, "t7_zero_mask");
    checkStr("t7_zero_stream", lastGot, "39 3d 01");
    bus.val_valid_i = 1;
    @(posedge clk);
    #1;
    bus.val_valid_i = 0;
    @(negedge clk);
    check("t7_val_in_idle", {bus.busy_o, bus.byte_valid_o}, 0);
    sendTag(32'h38, 5'b00001, 0);
    expTag(32'h38, 5'b00001, 0);
    waitFor(0, "t7_tag_done", n);
    sendVal(24'h434241, 3'b111);
    expVal(24'h434241, 3'b111);
    bus.tag_i = 32'h55;
    bus.t_size_i = 5'b00001;
    bus.tag_valid_i = 1;
    @(posedge clk);
    #1;
    bus.tag_valid_i = 0;
    waitFor(0, "t7_val_done", n);
    compareBytes("t7_ignored_tag");
    foreach (vecs[i]) begin
      doField(vecs[i].tag, vecs[i].ts, VW'(vecs[i].val), SZ'(vecs[i].vs), $sformatf("vec%0d", i));
      check($sformatf("vec%0d_len", i), 64'(lastLen), 64'(vecs[i].expLen));
    end
    doCk(32'h3031, 5'b00011, "vec_ck");
    randReady = 1;
    for (int k = 0; k < 40; k++) begin
      for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
      c = $urandom_range(0, 32);
      vs = {$urandom, $urandom};
      lowMask = 32'((64'd1 << c) - 64'd1);
      vs[31:0] = vs[31:0] & lowMask;
      if (c > 0) vs[c-1] = 1'b1;
      doField($urandom, 5'($urandom_range(0, 31)), v, vs, $sformatf("rand%0d", k));
      if (k % 8 == 7) doCk($urandom, 5'($urandom_range(0, 31)), $sformatf("rand_ck%0d", k));
    end
    randReady = 0;
    bus.byte_ready_i = 1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
